// File: rtl/mem_map_pkg.sv
// mem_map_pkg: MMIO map, TX_STATUS bit positions and store-lane alignment for mem_responder
package mem_map_pkg;
  localparam logic [31:0] IO_BASE_DEF = 32'h0001_0000;
  localparam logic [3:0] REG_LEDS = 4'h0;
  localparam logic [3:0] REG_TX_DATA = 4'h1;
  localparam logic [3:0] REG_TX_STATUS = 4'h2;
  localparam logic [3:0] REG_CYCLE_LO = 4'h3;
  localparam logic [3:0] REG_CYCLE_HI = 4'h4;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVF = 2;
  localparam int ST_COUNT = 4;
  // The core sends rs2 unshifted, so narrow stores are replicated across lanes
  function automatic logic [31:0] align_wdata(input logic [31:0] wd, input logic [3:0] mask);
    return $onehot(mask) ? {4{wd[7:0]}} :
           (mask == 4'b0011 || mask == 4'b1100) ? {2{wd[15:0]}} : wd;
  endfunction
endpackage

// File: rtl/tx_fifo.sv
// tx_fifo: byte-wide sync FIFO; a push is taken when not full or when a pop frees a slot
module tx_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [7:0]                   push_data,
  input  logic                         pop,
  output logic [7:0]                   head,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word RAM plus LED/cycle-counter/TX-FIFO MMIO behind the core's single memory port
module mem_responder
  import mem_map_pkg::*;
#(
  parameter int          DEPTH      = 1024,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [31:0] IO_BASE    = IO_BASE_DEF,
  parameter string       INIT_FILE  = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemWrite,
  input  logic [3:0]  WriteMask,
  output logic [31:0] ReadData,
  output logic [7:0]  leds,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  logic [31:0] mem [DEPTH];
  logic [31:0] wd, rdata, cycle_hi;
  logic [63:0] cycle_cnt;
  logic [AW-1:0] idx;
  logic [3:0] reg_sel;
  logic [1:0] rst_sq;
  logic rst_n_i, ram_hit, io_hit, lane0_wr, push, pop, empty, full, ovf;
  logic [7:0] head, status;
  logic [CW-1:0] count;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sq <= '0;
    else rst_sq <= {rst_sq[0], 1'b1};
  assign rst_n_i = rst_sq[1];
  assign ram_hit = Address < 32'(DEPTH * 4);
  assign io_hit = !ram_hit && Address[31:6] == IO_BASE[31:6];
  assign idx = Address[AW+1:2];
  assign reg_sel = Address[5:2];
  assign wd = align_wdata(WriteData, WriteMask);
  assign lane0_wr = io_hit && MemWrite && WriteMask[0];
  assign push = lane0_wr && reg_sel == REG_TX_DATA;
  assign pop = tx_valid && tx_ready;
  assign tx_valid = !empty;
  assign tx_data = empty ? 8'h00 : head;
  always_comb begin
    status = '0;
    status[ST_EMPTY] = empty;
    status[ST_FULL] = full;
    status[ST_OVF] = ovf;
    status[ST_COUNT+:4] = 4'(count);
  end
  always_comb
    rdata = ram_hit ? mem[idx] :
            !io_hit ? 32'h0 :
            reg_sel == REG_LEDS ? {24'h0, leds} :
            reg_sel == REG_TX_STATUS ? {24'h0, status} :
            reg_sel == REG_CYCLE_LO ? cycle_cnt[31:0] :
            reg_sel == REG_CYCLE_HI ? cycle_hi : 32'h0;
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++)
      if (MemWrite && ram_hit && WriteMask[k]) mem[idx][8*k+:8] <= wd[8*k+:8];
  always_ff @(posedge clk or negedge rst_n_i)
    if (!rst_n_i) begin
      ReadData <= '0;
      leds <= '0;
      cycle_cnt <= '0;
      cycle_hi <= '0;
      ovf <= 1'b0;
    end else begin
      ReadData <= rdata;
      cycle_cnt <= cycle_cnt + 64'd1;
      if (io_hit && reg_sel == REG_CYCLE_LO) cycle_hi <= cycle_cnt[63:32];
      if (lane0_wr && reg_sel == REG_LEDS) leds <= wd[7:0];
      if (push && full && !pop) ovf <= 1'b1;
      else if (lane0_wr && reg_sel == REG_TX_STATUS && wd[ST_OVF]) ovf <= 1'b0;
    end
  tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset_n(rst_n_i), .push(push), .push_data(wd[7:0]), .pop(pop),
    .head(head), .empty(empty), .full(full), .count(count)
  );
endmodule
